miner_work_scheduler: RTL

Sequences the double-SHA-256 hasher pair across a host-supplied nonce range and buffers golden nonces for the serial transmitter. Sits between `serial_receive`/`serial_transmit` and the hasher datapath in the miner top level. It replaces the free-running nonce counter with range-bounded, abortable work, and adds stale-result flushing and a small result FIFO.

---
 rtl/miner_work_scheduler_if.sv | 38 +++
 rtl/miner_work_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/miner_work_scheduler_if.sv
// Signal bundle between the work scheduler, the host serial link and the hasher pair.
// The slave modport is the scheduler's view; master is the surrounding miner top level.
interface miner_work_scheduler_if;
    logic         work_valid;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic [255:0] hs_midstate;
    logic [95:0]  hs_data;
    logic [31:0]  hs_nonce;
    logic         hs_feedback;
    logic [5:0]   hs_cnt;
    logic         hs_issue;
    logic         hit;
    logic [31:0]  hit_nonce;
    logic [31:0]  tx_word;
    logic         tx_send;
    logic         tx_busy;
    logic         busy;
    logic         work_done;
    logic         overflow;
    logic [15:0]  hit_count;

    modport master (
        output work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end,
        output hit, hit_nonce, tx_busy,
        input  hs_midstate, hs_data, hs_nonce, hs_feedback, hs_cnt, hs_issue,
        input  tx_word, tx_send, busy, work_done, overflow, hit_count
    );

    modport slave (
        input  work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end,
        input  hit, hit_nonce, tx_busy,
        output hs_midstate, hs_data, hs_nonce, hs_feedback, hs_cnt, hs_issue,
        output tx_word, tx_send, busy, work_done, overflow, hit_count
    );
endinterface

// File: rtl/miner_work_scheduler.sv
// Range-bounded, abortable nonce sequencer for the double-SHA-256 hasher pair,
// with stale-hit flushing and a small golden-nonce FIFO toward the transmitter.
module miner_work_scheduler #(
    parameter int LOOP_LOG2  = 0,
    parameter int LATENCY    = 131,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    miner_work_scheduler_if.slave bus
);
    localparam int CW = $clog2(LATENCY + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [5:0]    CNT_LAST   = 6'((1 << LOOP_LOG2) - 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(LATENCY + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(LATENCY);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    // IDLE wait | LOAD prime first slot | RUN issue slots | DRAIN await in-flight hits | DONE idle
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q;
    logic [255:0]  midstate_q;
    logic [95:0]   data_q;
    logic [31:0]   start_q;
    logic [31:0]   end_q;
    logic [31:0]   nonce_q;
    logic [5:0]    cnt_q;
    logic          feedback_q;
    logic          issue_q;
    logic [CW-1:0] flush_q;
    logic [CW-1:0] drain_q;
    logic [31:0]   tx_word_q;
    logic          tx_send_q;
    logic          busy_q;
    logic          work_done_q;
    logic          overflow_q;
    logic [15:0]   hit_count_q;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    logic          hit_ok;
    logic          pop;
    logic          push;

    assign hit_ok = bus.hit && !bus.work_valid && (flush_q == '0) &&
                    ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign pop    = (count_q != '0) && !bus.tx_busy && !tx_send_q;
    // A pop in the same cycle frees the slot the incoming hit needs.
    assign push   = hit_ok && ((count_q != FIFO_FULL) || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.hit_nonce;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            midstate_q  <= '0;
            data_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            nonce_q     <= '0;
            cnt_q       <= '0;
            feedback_q  <= 1'b0;
            issue_q     <= 1'b0;
            flush_q     <= '0;
            drain_q     <= '0;
            tx_word_q   <= '0;
            tx_send_q   <= 1'b0;
            busy_q      <= 1'b0;
            work_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            hit_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (bus.work_valid) begin
                state_q     <= S_LOAD;
                midstate_q  <= bus.work_midstate;
                data_q      <= bus.work_data;
                start_q     <= bus.work_nonce_start;
                end_q       <= bus.work_nonce_end;
                cnt_q       <= '0;
                feedback_q  <= 1'b0;
                issue_q     <= 1'b0;
                flush_q     <= FLUSH_LOAD;
                busy_q      <= 1'b1;
                work_done_q <= 1'b0;
                overflow_q  <= 1'b0;
                hit_count_q <= '0;
            end else begin
                work_done_q <= 1'b0;
                if (flush_q != '0) begin
                    flush_q <= flush_q - 1'b1;
                end
                case (state_q)
                    S_LOAD: begin
                        state_q    <= S_RUN;
                        nonce_q    <= start_q;
                        cnt_q      <= '0;
                        feedback_q <= 1'b0;
                        issue_q    <= 1'b1;
                    end
                    S_RUN: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q      <= '0;
                            feedback_q <= 1'b0;
                            if (nonce_q == end_q) begin
                                state_q <= S_DRAIN;
                                drain_q <= DRAIN_LOAD;
                                issue_q <= 1'b0;
                            end else begin
                                nonce_q <= nonce_q + 32'd1;
                                issue_q <= 1'b1;
                            end
                        end else begin
                            cnt_q      <= cnt_q + 6'd1;
                            feedback_q <= 1'b1;
                            issue_q    <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        // Loaded with LATENCY, so leaving on 1 gives exactly LATENCY drain cycles.
                        if (drain_q <= CW'(1)) begin
                            state_q     <= S_DONE;
                            drain_q     <= '0;
                            busy_q      <= 1'b0;
                            work_done_q <= 1'b1;
                        end else begin
                            drain_q <= drain_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (hit_ok) begin
                    if (hit_count_q != 16'hFFFF) begin
                        hit_count_q <= hit_count_q + 16'd1;
                    end
                    if (!push) begin
                        overflow_q <= 1'b1;
                    end
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                tx_send_q <= 1'b1;
                tx_word_q <= fifo_mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end else begin
                tx_send_q <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    assign bus.hs_midstate = midstate_q;
    assign bus.hs_data     = data_q;
    assign bus.hs_nonce    = nonce_q;
    assign bus.hs_feedback = feedback_q;
    assign bus.hs_cnt      = cnt_q;
    assign bus.hs_issue    = issue_q;
    assign bus.tx_word     = tx_word_q;
    assign bus.tx_send     = tx_send_q;
    assign bus.busy        = busy_q;
    assign bus.work_done   = work_done_q;
    assign bus.overflow    = overflow_q;
    assign bus.hit_count   = hit_count_q;
endmodule
